cvxif_result_tx: RTL and testbench

CVXIF_RESULT_TX -- requirements
Module: cvxif_result_tx

---
 rtl/cvxif_pkg.sv | 12 +
 rtl/cvxif_result_tx.sv | 123 ++++++++++++
 tb/tb_cvxif_result_tx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cvxif_pkg.sv
// ---------------------------------------------------------------------------
// cvxif_pkg
// Shared CV-X-IF type widths for the coprocessor result path.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cvxif_pkg;
  parameter int unsigned X_ID_WIDTH = 4;
endpackage

`default_nettype wire

// File: rtl/cvxif_result_tx.sv
// ---------------------------------------------------------------------------
// cvxif_result_tx
// Result queue between the MAC unit and the CV-X-IF result channel, with
// in-order issue, flush, and duplicate pending-ID detection.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cvxif_result_tx
  import cvxif_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [X_ID_WIDTH-1:0]     in_id_i,
  input  logic [31:0]               in_data_i,
  input  logic [4:0]                in_rd_i,
  input  logic                      in_we_i,
  output logic                      result_valid_o,
  input  logic                      result_ready_i,
  output logic [X_ID_WIDTH-1:0]     result_id_o,
  output logic [31:0]               result_data_o,
  output logic [4:0]                result_rd_o,
  output logic                      result_we_o,
  input  logic                      flush_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      dup_err_o
);

  localparam int unsigned C_PTR_W = $clog2(DEPTH);
  localparam int unsigned C_CNT_W = C_PTR_W + 1;
  localparam int unsigned C_NUM_ID = 2 ** X_ID_WIDTH;

  logic [C_PTR_W-1:0]    r_wptr;
  logic [C_PTR_W-1:0]    r_rptr;
  logic [C_CNT_W-1:0]    r_count;
  logic [C_NUM_ID-1:0]   r_pending;
  logic                  r_dup_err;

  logic [X_ID_WIDTH-1:0] r_id_q   [DEPTH];
  logic [31:0]           r_data_q [DEPTH];
  logic [4:0]            r_rd_q   [DEPTH];
  logic                  r_we_q   [DEPTH];

  logic                  w_push;
  logic                  w_pop;
  logic [X_ID_WIDTH-1:0] w_head_id;
  logic                  w_dup;
  logic [C_NUM_ID-1:0]   w_pending_nxt;

  assign in_ready_o     = (r_count < C_CNT_W'(DEPTH));
  assign result_valid_o = (r_count != '0);
  assign w_push         = in_valid_i && in_ready_o && !flush_i;
  assign w_pop          = result_valid_o && result_ready_i && !flush_i;
  assign w_head_id      = r_id_q[r_rptr];

  // Empty queue presents zeros so stale storage never leaks onto the bus.
  assign result_id_o   = result_valid_o ? w_head_id         : '0;
  assign result_data_o = result_valid_o ? r_data_q[r_rptr]  : '0;
  assign result_rd_o   = result_valid_o ? r_rd_q[r_rptr]    : '0;
  assign result_we_o   = result_valid_o ? r_we_q[r_rptr]    : 1'b0;
  assign count_o       = r_count;
  assign dup_err_o     = r_dup_err;

  // A same-cycle pop of the same ID releases the bit before the push re-arms it.
  assign w_dup = w_push && r_pending[in_id_i] && !(w_pop && (w_head_id == in_id_i));

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) begin
      w_pending_nxt[w_head_id] = 1'b0;
    end
    if (w_push) begin
      w_pending_nxt[in_id_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_pending <= '0;
      r_dup_err <= 1'b0;
    end else if (flush_i) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_pending <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + C_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + C_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_pending <= w_pending_nxt;
      if (w_dup) begin
        r_dup_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_id_q[r_wptr]   <= in_id_i;
      r_data_q[r_wptr] <= in_data_i;
      r_rd_q[r_wptr]   <= in_rd_i;
      r_we_q[r_wptr]   <= in_we_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cvxif_result_tx.sv
// ---------------------------------------------------------------------------
// tb_cvxif_result_tx
// Self-checking bench: queue-based reference model plus directed scenarios.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cvxif_result_tx;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDW   = cvxif_pkg::X_ID_WIDTH;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [IDW-1:0]  in_id_i = '0;
  logic [31:0]     in_data_i = '0;
  logic [4:0]      in_rd_i = '0;
  logic            in_we_i = 1'b0;
  logic            result_valid_o;
  logic            result_ready_i = 1'b0;
  logic [IDW-1:0]  result_id_o;
  logic [31:0]     result_data_o;
  logic [4:0]      result_rd_o;
  logic            result_we_o;
  logic            flush_i = 1'b0;
  logic [CW-1:0]   count_o;
  logic            dup_err_o;

  cvxif_result_tx #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_id_i(in_id_i), .in_data_i(in_data_i), .in_rd_i(in_rd_i), .in_we_i(in_we_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .flush_i(flush_i), .count_o(count_o), .dup_err_o(dup_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    data;
    logic [4:0]     rd;
    logic           we;
  } ent_t;

  ent_t q[$];
  bit   pend [2**IDW];
  bit   m_dup;
  bit   chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted beats and a set of pending IDs.
  always @(posedge clk_i) begin
    bit   do_push, do_pop;
    ent_t e;
    if (rst_i) begin
      q.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      m_dup = 1'b0;
    end else if (flush_i) begin
      q.delete();
      foreach (pend[i]) pend[i] = 1'b0;
    end else begin
      do_push = in_valid_i && (q.size() < DEPTH);
      do_pop  = (q.size() != 0) && result_ready_i;
      if (do_pop) begin
        pend[q[0].id] = 1'b0;
        void'(q.pop_front());
      end
      if (do_push) begin
        if (pend[in_id_i]) m_dup = 1'b1;
        pend[in_id_i] = 1'b1;
        e.id = in_id_i; e.data = in_data_i; e.rd = in_rd_i; e.we = in_we_i;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("count", 32'(count_o), 32'(q.size()));
      chk("in_ready", 32'(in_ready_o), 32'(q.size() < DEPTH));
      chk("valid", 32'(result_valid_o), 32'(q.size() != 0));
      chk("dup_err", 32'(dup_err_o), 32'(m_dup));
      if (q.size() != 0) begin
        chk("id", 32'(result_id_o), 32'(q[0].id));
        chk("data", result_data_o, q[0].data);
        chk("rd", 32'(result_rd_o), 32'(q[0].rd));
        chk("we", 32'(result_we_o), 32'(q[0].we));
      end else begin
        chk("id_idle", 32'(result_id_o), 32'd0);
        chk("data_idle", result_data_o, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit v, input int id, input logic [31:0] d, input int rd, input bit we);
    in_valid_i = v;
    in_id_i    = IDW'(id);
    in_data_i  = d;
    in_rd_i    = 5'(rd);
    in_we_i    = we;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; drive(0, 0, 0, 0, 0); flush_i = 1'b0; result_ready_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    chk_en = 1'b1;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_ready", 32'(in_ready_o), 32'd1);
    chk("rst_valid", 32'(result_valid_o), 32'd0);

    // Single result, 1-cycle latency, popped immediately.
    result_ready_i = 1'b1;
    drive(1, 3, 32'h0000_00AB, 5, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("s1_valid", 32'(result_valid_o), 32'd1);
    chk("s1_id", 32'(result_id_o), 32'd3);
    chk("s1_data", result_data_o, 32'h0000_00AB);
    chk("s1_rd", 32'(result_rd_o), 32'd5);
    tick();
    chk("s1_count_after_pop", 32'(count_o), 32'd0);

    // Fill with ready low; fifth beat refused, head held.
    result_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, i, 32'h100 + i, i + 1, i[0]);
      tick();
    end
    chk("s2_count", 32'(count_o), 32'd4);
    chk("s2_ready", 32'(in_ready_o), 32'd0);
    drive(1, 9, 32'hDEAD, 7, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("s2_hold_id", 32'(result_id_o), 32'd0);
      chk("s2_hold_data", result_data_o, 32'h100);
    end

    // Full with push+pop together: only the pop lands.
    result_ready_i = 1'b1;
    tick();
    chk("s3_count", 32'(count_o), 32'd3);
    chk("s3_head", 32'(result_id_o), 32'd1);
    for (int i = 0; i < 6; i++) begin
      drive(i % 3 != 2, 10 + i, 32'h200 + i, i, 1);
      result_ready_i = (i % 2 == 0);
      tick();
    end

    // Flush with a concurrent push.
    flush_i = 1'b1; drive(0, 0, 0, 0, 0); tick(); flush_i = 1'b0;
    result_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 4 + i, 32'h300 + i, 2, 0);
      tick();
    end
    flush_i = 1'b1; drive(1, 8, 32'h3FF, 3, 1);
    tick();
    flush_i = 1'b0; drive(0, 0, 0, 0, 0);
    chk("s4_count", 32'(count_o), 32'd0);
    chk("s4_valid", 32'(result_valid_o), 32'd0);
    tick();
    chk("s4_still_empty", 32'(count_o), 32'd0);

    // Duplicate ID detection and its sticky behaviour.
    do_reset();
    drive(1, 2, 32'h11, 1, 1); tick();
    drive(1, 2, 32'h22, 2, 1); tick();
    drive(0, 0, 0, 0, 0);
    chk("s5_dup_set", 32'(dup_err_o), 32'd1);
    result_ready_i = 1'b1;
    tick(); tick();
    chk("s5_dup_sticky", 32'(dup_err_o), 32'd1);
    chk("s5_drained", 32'(count_o), 32'd0);
    do_reset();
    drive(1, 2, 32'h33, 3, 1); tick();
    result_ready_i = 1'b1;
    drive(1, 2, 32'h44, 4, 1); tick();
    drive(0, 0, 0, 0, 0); result_ready_i = 1'b0;
    chk("s5_swap_no_dup", 32'(dup_err_o), 32'd0);
    chk("s5_swap_count", 32'(count_o), 32'd1);
    chk("s5_swap_data", result_data_o, 32'h44);

    // Reset while a result is stalled on the bus.
    drive(1, 7, 32'h55, 9, 1); tick();
    drive(0, 0, 0, 0, 0);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("s6_valid", 32'(result_valid_o), 32'd0);
    chk("s6_ready", 32'(in_ready_o), 32'd1);
    chk("s6_id", 32'(result_id_o), 32'd0);
    chk("s6_data", result_data_o, 32'd0);
    chk("s6_rd", 32'(result_rd_o), 32'd0);
    chk("s6_we", 32'(result_we_o), 32'd0);
    chk("s6_count", 32'(count_o), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 2**IDW - 1),
            $urandom, $urandom_range(0, 31), $urandom_range(0, 1));
      result_ready_i = $urandom_range(0, 1);
      flush_i = ($urandom_range(0, 99) < 3);
      rst_i   = ($urandom_range(0, 199) < 1);
      tick();
    end
    rst_i = 1'b0; flush_i = 1'b0; drive(0, 0, 0, 0, 0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
